fft_out_reorder: RTL and testbench
==================================

Name: fft_out_reorder

Overview:
- Downstream neighbour of the 512-point, 16-lane FFT. Consumes its bit-reversed-order output bursts (32 blocks × 16 lanes × 13-bit I/Q).
- Emits the same frame in natural frequency order.
- Ping-pong double buffer: one frame is written while the previous frame is read out, so back-to-back frames stream without stalls.

Parameters:
- DATA_W, 13, bit width of each I and Q sample (in and out).
- NUM, 16, lanes per block.
- N, 512, points per frame; LOG2N = 9, BLK = N/NUM = 32 blocks per frame.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rstn, input, 1, asynchronous active-low reset.
- valid_in, input, 1, din_i/din_q hold one valid block this cycle.
- din_i, input, DATA_W*NUM, lane j at bits [j*DATA_W +: DATA_W], signed, bit-reversed order.
- din_q, input, DATA_W*NUM, same packing as din_i.
- valid_out, output, 1, dout_i/dout_q hold one natural-order block.
- dout_i, output, DATA_W*NUM, same packing, natural order.
- dout_q, output, DATA_W*NUM, same packing.

Behaviour:
- Index mapping (input side):
  - Input block c (0..31, counted over valid_in cycles only), lane l, carries X[bitrev9(c*NUM+l)].
  - bitrev9 reverses the 9 index bits.
- Index mapping (output side):
  - Output block k, lane l, carries X[k*NUM+l].
- Storage: two banks of N entries × 2*DATA_W bits (I,Q).
  - wr_bank selects the bank being filled; rd_bank selects the bank being read.
  - Memory contents are not reset.
- Write side:
  - Each valid_in cycle writes all 16 lanes to addresses bitrev9(wr_blk*NUM+l) of wr_bank, then wr_blk increments.
  - wr_blk is a 5-bit counter.
  - Gaps (valid_in=0) hold wr_blk; no write occurs.
  - At wr_blk=31 with valid_in=1 (edge E): wr_blk wraps to 0, wr_bank toggles, and a read of the just-filled bank is launched.
- Read side FSM, states RD_IDLE and RD_RUN:
  - RD_IDLE → RD_RUN on the frame-complete edge E; rd_bank = the just-filled bank, rd_blk = 0.
  - In RD_RUN: each edge registers block rd_blk onto dout_i/dout_q, sets valid_out=1, and increments rd_blk.
  - RD_RUN → RD_IDLE after rd_blk=31 is registered.
  - valid_out is high for exactly 32 consecutive cycles, after edges E+1..E+32.
  - A frame completing at edge E+32 (the earliest possible) chains straight into RD_RUN with no valid_out gap.
- Latency: first natural-order block valid 1 cycle after the last input block is accepted.
- Hazard-free by construction: a frame takes ≥32 cycles to fill, so a bank is never rewritten while being read. No backpressure port exists.
- When valid_out=0, dout_i/dout_q hold their last value.
- Partial frames are never emitted.
- Reset, asserted at any time (including mid-frame or mid-burst), clears asynchronously:
  - valid_out=0, dout_i=0, dout_q=0;
  - wr_blk=0, rd_blk=0, wr_bank=0, rd_bank=0, FSM=RD_IDLE.
- After reset, any partially written or partially read frame is discarded; the next valid_in block is block 0 of a new frame.

Optional Feature:
- Macro: FFT_REORDER_MARK_EN.
- Defined: adds output ports sof_out (1 bit) and eof_out (1 bit).
  - sof_out=1 on the cycle with valid_out=1 and output block 0.
  - eof_out=1 on the cycle with output block 31.
  - Both are 0 otherwise and 0 on reset.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Index frame: input block c, lane l, din_i = bitrev9(c*16+l), din_q = -bitrev9(c*16+l), valid_in continuous for 32 cycles → valid_out high 32 cycles starting 1 cycle after the last input; output block k, lane l, dout_i = k*16+l, dout_q = -(k*16+l).
- Back-to-back: frames A (din_i=index) and B (din_i=index+1000) with valid_in high 64 cycles → 64-cycle unbroken valid_out; first 32 blocks are A in natural order, next 32 are B.
- Gapped input: index frame with valid_in toggling 1,0,1,0 → output identical to scenario 1; valid_out rises 1 cycle after the 32nd valid block.
- Reset mid-frame: rstn pulsed low after 10 input blocks, then a full index frame → valid_out=0 during and after the reset until the new frame completes; exactly 32 correct output blocks.
- Reset mid-burst: rstn low after 5 output blocks → valid_out and dout drop to 0 immediately; no further output until a new 32-block frame arrives.
- With FFT_REORDER_MARK_EN defined, run scenario 2 → sof_out pulses on output cycles 0 and 32; eof_out pulses on cycles 31 and 63.

Source files
------------

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: converts bit-reversed FFT output bursts into natural frequency order.
// Frames are double-buffered: one bank fills while the other drains, so frames can
// arrive back to back with no stalls.
// Optional feature macro: FFT_REORDER_MARK_EN (adds the sof_out/eof_out frame markers).
// Ports:
//   clk       - single clock, all state updates on the rising edge
//   rstn      - asynchronous active-low reset
//   valid_in  - din_i/din_q carry one bit-reversed block this cycle
//   din_i/q   - NUM lanes of signed DATA_W samples, lane j at [j*DATA_W +: DATA_W]
//   valid_out - dout_i/dout_q carry one natural-order block
//   dout_i/q  - same packing as the inputs, natural order; held while valid_out=0
//   sof_out   - (FFT_REORDER_MARK_EN) marks output block 0 of a frame
//   eof_out   - (FFT_REORDER_MARK_EN) marks the last output block of a frame
module fft_out_reorder #(
   parameter int DATA_W = 13,
   parameter int NUM    = 16,
   parameter int N      = 512
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  valid_in,
   input  logic [DATA_W*NUM-1:0] din_i,
   input  logic [DATA_W*NUM-1:0] din_q,
   output logic                  valid_out,
   output logic [DATA_W*NUM-1:0] dout_i,
   output logic [DATA_W*NUM-1:0] dout_q
`ifdef FFT_REORDER_MARK_EN
   ,
   output logic                  sof_out,
   output logic                  eof_out
`endif
);
   localparam int LOG2N  = $clog2(N);
   localparam int LANE_W = $clog2(NUM);
   localparam int BLK    = N / NUM;
   localparam int BLK_W  = $clog2(BLK);
   localparam int E_W    = 2 * DATA_W;
   localparam logic [BLK_W-1:0] LAST = BLK_W'(BLK - 1);
   localparam logic [0:0] RD_IDLE = 1'b0;
   localparam logic [0:0] RD_RUN  = 1'b1;

   // Each entry packs {I, Q}; contents are deliberately not reset.
   logic [E_W-1:0]   mem [2][N];
   logic [BLK_W-1:0] wr_blk, rd_blk;
   logic             wr_bank, rd_bank;
   logic [0:0]       state;
   logic             frame_done;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int b = 0; b < LOG2N; b++) r[b] = a[LOG2N-1-b];
      return r;
   endfunction

   // Last block of a frame accepted this cycle: bank swap and readout launch.
   assign frame_done = valid_in && wr_blk == LAST;

   always_ff @(posedge clk)
      if (valid_in)
         for (int l = 0; l < NUM; l++)
            mem[wr_bank][bitrev({wr_blk, LANE_W'(l)})] <= {din_i[l*DATA_W +: DATA_W], din_q[l*DATA_W +: DATA_W]};

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         wr_blk  <= '0;
         wr_bank <= 1'b0;
      end else if (valid_in) begin
         wr_blk <= wr_blk + 1'b1;
         if (frame_done) wr_bank <= ~wr_bank;
      end

   // A new frame can only complete once the previous readout has reached its last
   // block, so frame_done takes priority and chains directly into the next readout.
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state     <= RD_IDLE;
         rd_blk    <= '0;
         rd_bank   <= 1'b0;
         valid_out <= 1'b0;
         dout_i    <= '0;
         dout_q    <= '0;
`ifdef FFT_REORDER_MARK_EN
         sof_out   <= 1'b0;
         eof_out   <= 1'b0;
`endif
      end else begin
         valid_out <= state == RD_RUN;
`ifdef FFT_REORDER_MARK_EN
         sof_out   <= state == RD_RUN && rd_blk == '0;
         eof_out   <= state == RD_RUN && rd_blk == LAST;
`endif
         if (state == RD_RUN)
            for (int l = 0; l < NUM; l++) begin
               dout_i[l*DATA_W +: DATA_W] <= mem[rd_bank][{rd_blk, LANE_W'(l)}][E_W-1 -: DATA_W];
               dout_q[l*DATA_W +: DATA_W] <= mem[rd_bank][{rd_blk, LANE_W'(l)}][DATA_W-1:0];
            end
         if (frame_done) begin
            state   <= RD_RUN;
            rd_bank <= wr_bank;
            rd_blk  <= '0;
         end else if (state == RD_RUN) begin
            rd_blk <= rd_blk + 1'b1;
            if (rd_blk == LAST) state <= RD_IDLE;
         end
      end
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: randomized and directed self-checking bench for fft_out_reorder.
// The reference model holds each frame as a plain array X[0..511]; inputs are drawn
// from X at bit-reversed indices and every completed frame queues its 32
// natural-order blocks, which must then appear one per cycle on the outputs.
module tb_fft_out_reorder;
   localparam int W  = 13;
   localparam int L  = 16;
   localparam int NP = 512;
   localparam int B  = NP / L;
   localparam int DW = W * L;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          valid_in = 1'b0;
   logic [DW-1:0] din_i = '0;
   logic [DW-1:0] din_q = '0;
   logic          valid_out;
   logic [DW-1:0] dout_i;
   logic [DW-1:0] dout_q;
`ifdef FFT_REORDER_MARK_EN
   logic          sof_out;
   logic          eof_out;
`endif

   logic [W-1:0]  xi [NP];
   logic [W-1:0]  xq [NP];
   logic [DW-1:0] qi [$];
   logic [DW-1:0] qq [$];
   int            qk [$];
   logic [DW-1:0] last_i = '0;
   logic [DW-1:0] last_q = '0;
   int            in_blk = 0;
   int            vectors = 0;
   int            miscompares = 0;
   int            n;
   bit            v;

   fft_out_reorder dut (
      .clk(clk), .rstn(rstn), .valid_in(valid_in), .din_i(din_i), .din_q(din_q),
      .valid_out(valid_out), .dout_i(dout_i), .dout_q(dout_q)
`ifdef FFT_REORDER_MARK_EN
      , .sof_out(sof_out), .eof_out(eof_out)
`endif
   );

   always #5 clk = ~clk;

   function automatic int br9(input int a);
      int r = 0;
      for (int b = 0; b < 9; b++) if (a[b]) r |= 1 << (8 - b);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic set_index(input int off);
      for (int i = 0; i < NP; i++) begin
         xi[i] = W'(i + off);
         xq[i] = W'(-(i + off));
      end
   endtask

   task automatic set_random();
      for (int i = 0; i < NP; i++) begin
         xi[i] = W'($urandom);
         xq[i] = W'($urandom);
      end
   endtask

   // One clock: drive, sample 1 time unit after the edge, then advance the model.
   task automatic tick(input bit vin);
      logic [DW-1:0] bi, bq;
      valid_in = vin;
      for (int l = 0; l < L; l++) begin
         din_i[l*W +: W] = vin ? xi[br9(in_blk*L + l)] : W'($urandom);
         din_q[l*W +: W] = vin ? xq[br9(in_blk*L + l)] : W'($urandom);
      end
      @(posedge clk);
      #1;
      if (qi.size() > 0) begin
         chk("valid_out", DW'(valid_out), DW'(1));
         chk("dout_i", dout_i, qi[0]);
         chk("dout_q", dout_q, qq[0]);
`ifdef FFT_REORDER_MARK_EN
         chk("sof_out", DW'(sof_out), DW'(qk[0] == 0));
         chk("eof_out", DW'(eof_out), DW'(qk[0] == B - 1));
`endif
         last_i = qi.pop_front();
         last_q = qq.pop_front();
         void'(qk.pop_front());
      end else begin
         chk("valid_out_idle", DW'(valid_out), DW'(0));
         chk("dout_i_hold", dout_i, last_i);
         chk("dout_q_hold", dout_q, last_q);
`ifdef FFT_REORDER_MARK_EN
         chk("sof_out_idle", DW'(sof_out), DW'(0));
         chk("eof_out_idle", DW'(eof_out), DW'(0));
`endif
      end
      if (vin) begin
         in_blk++;
         if (in_blk == B) begin
            in_blk = 0;
            for (int k = 0; k < B; k++) begin
               for (int l = 0; l < L; l++) begin
                  bi[l*W +: W] = xi[k*L + l];
                  bq[l*W +: W] = xq[k*L + l];
               end
               qi.push_back(bi);
               qq.push_back(bq);
               qk.push_back(k);
            end
         end
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      valid_in = 1'b0;
      #1;
      chk("rst_valid_out", DW'(valid_out), DW'(0));
      chk("rst_dout_i", dout_i, '0);
      chk("rst_dout_q", dout_q, '0);
      qi.delete();
      qq.delete();
      qk.delete();
      in_blk = 0;
      last_i = '0;
      last_q = '0;
      @(posedge clk);
      #1;
      chk("rst_hold_valid", DW'(valid_out), DW'(0));
      rstn = 1'b1;
   endtask

   initial begin
      #2;
      chk("por_valid_out", DW'(valid_out), DW'(0));
      chk("por_dout_i", dout_i, '0);
      chk("por_dout_q", dout_q, '0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (3) tick(1'b0);
      set_index(0);
      repeat (B) tick(1'b1);
      repeat (B + 2) tick(1'b0);
      set_index(0);
      repeat (B) tick(1'b1);
      set_index(1000);
      repeat (B) tick(1'b1);
      repeat (B + 2) tick(1'b0);
      set_index(0);
      for (int i = 0; i < 2 * B; i++) tick(i % 2 == 0);
      repeat (B + 2) tick(1'b0);
      repeat (3) begin
         set_random();
         n = 0;
         while (n < B) begin
            v = 1'($urandom_range(0, 1));
            tick(v);
            if (v) n++;
         end
      end
      repeat (B + 2) tick(1'b0);
      set_index(0);
      repeat (10) tick(1'b1);
      do_reset();
      repeat (3) tick(1'b0);
      set_index(0);
      repeat (B) tick(1'b1);
      repeat (B + 2) tick(1'b0);
      set_random();
      repeat (B) tick(1'b1);
      repeat (5) tick(1'b0);
      do_reset();
      repeat (5) tick(1'b0);
      set_index(7);
      repeat (B) tick(1'b1);
      repeat (B + 2) tick(1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
